camera_update_scheduler: RTL and testbench
==========================================

// Module: camera_update_scheduler
// PURPOSE
//  Sequences the camera-basis compute unit (gyro -> view vectors) from the pixel clock domain.
//  - On frame boundaries, issues start requests to the compute unit.
//  - Captures its 9-vector result, or a debug override, into a shadow register.
//  - Commits the shadow to the renderer only at new_frame, so no frame ever renders with a torn basis.
//  - Sits between the view-vector compute unit, the debug (UART) override path and renderer camera_* inputs.
// PARAMETERS
//  W          32     width of each signed fixed-point vector component
//  FRAC       16     fractional bits; ONE = 1<<FRAC
//  FRAME_DIV  1      request a new basis every FRAME_DIV frames (>=1)
//  TIMEOUT    65535  max clk_in cycles to wait for done_in after start_out
// PORTS
//  clk_in         in   1      pixel clock; all logic on posedge
//  rst_in         in   1      asynchronous, active-high reset
//  new_frame_in   in   1      one-cycle frame-boundary pulse from video signal generator
//  start_out      out  1      one-cycle request pulse to compute unit
//  done_in        in   1      one-cycle result-valid pulse from compute unit
//  basis_in       in   9*W    {fx,fy,fz,ux,uy,uz,rx,ry,rz} from compute unit, valid with done_in
//  dbg_en_in      in   1      1 = capture dbg_basis_in instead of basis_in
//  dbg_basis_in   in   9*W    debug override basis, same packing
//  basis_out      out  9*W    committed basis to renderer, same packing
//  commit_out     out  1      one-cycle pulse: basis_out updated this cycle
//  busy_out       out  1      1 while in WAIT
//  timeout_out    out  1      sticky: a request timed out; cleared only by reset
//  missed_out     out  8      saturating count of frames that passed without commit while WAIT
// BEHAVIOUR
//  Reset (async, immediate):
//   - basis_out = forward (0,0,ONE), up (0,ONE,0), right (ONE,0,0)
//   - start_out, commit_out, busy_out, timeout_out = 0; missed_out = 0
//   - state = IDLE; div_cnt = 0; shadow = reset basis; tmo_cnt = 0
//  div_cnt: increments mod FRAME_DIV on every new_frame_in, in all states; due = (div_cnt==0) on that pulse.
//  FSM states: IDLE, WAIT, READY.
//   IDLE:
//    - new_frame_in & due -> start_out=1 next cycle, tmo_cnt=0, -> WAIT
//    - new_frame_in & !due -> stay IDLE
//   WAIT (busy_out=1):
//    - tmo_cnt increments each cycle.
//    - done_in -> shadow <= dbg_en_in ? dbg_basis_in : basis_in (sampled same cycle), -> READY
//    - done_in & new_frame_in same cycle -> basis_out <= captured value directly, commit_out=1 next cycle;
//      then start_out if due (-> WAIT, tmo_cnt=0), else -> IDLE
//    - new_frame_in without done_in -> missed_out += 1 (saturates at 255), stay WAIT
//    - tmo_cnt==TIMEOUT-1 without done_in -> timeout_out=1, -> IDLE; basis_out unchanged
//   READY:
//    - new_frame_in -> basis_out <= shadow, commit_out=1 next cycle;
//      due ? (start_out, -> WAIT) : -> IDLE
//    - done_in ignored
//  Output timing:
//   - start_out and commit_out are registered, exactly one cycle wide, asserted the cycle after the triggering new_frame_in.
//   - basis_out changes only in the cycle commit_out is high, so it is stable for an entire frame.
//  done_in in IDLE/READY ignored (no capture, no error). dbg_en_in is sampled only at capture.
//  Latency: commit occurs at the first new_frame_in at or after done_in, so worst case one frame plus compute time.
//  A pending READY shadow is discarded by reset.
// TESTING
//  1. Reset, then check basis_out = {0,0,ONE,0,ONE,0,ONE,0,0}, all flags 0;
//     new_frame at t0 -> start_out high exactly at t0+1.
//  2. Normal flow: done_in 100 cycles after start with basis_in=K -> no change until next new_frame;
//     then basis_out=K, commit_out 1 cycle, start_out same cycle.
//  3. dbg_en_in=1 at done_in with dbg_basis_in=D, basis_in=K -> committed basis_out=D;
//     FRAME_DIV=3 -> start_out on frames 0,3,6 only.
//  4. done_in coincident with new_frame_in (value K) -> basis_out=K and commit_out next cycle, no extra frame delay.
//  5. No done_in, TIMEOUT=50 -> timeout_out=1 at cycle 50, state IDLE, basis_out unchanged;
//     3 new_frames during a long WAIT -> missed_out=3.
//  6. Assert rst_in mid-WAIT and mid-READY -> outputs return to reset values asynchronously; late done_in ignored.

Source files
------------

// File: rtl/camera_update_scheduler.sv
// camera_update_scheduler
//   Sequences the camera-basis compute unit from the pixel clock domain.
//   On due frame boundaries it issues a start request, captures the returned
//   9-vector basis (or a debug override) into a shadow register, and commits
//   the shadow to the renderer only on new_frame so a frame never renders
//   with a torn basis.
//
// Ports
//   clk_in        in   1     pixel clock, all logic on posedge
//   rst_in        in   1     asynchronous active-high reset
//   new_frame_in  in   1     one-cycle frame-boundary pulse
//   start_out     out  1     one-cycle request pulse to the compute unit
//   done_in       in   1     one-cycle result-valid pulse from the compute unit
//   basis_in      in   9*W   {fx,fy,fz,ux,uy,uz,rx,ry,rz}, valid with done_in
//   dbg_en_in     in   1     capture dbg_basis_in instead of basis_in
//   dbg_basis_in  in   9*W   debug override basis, same packing
//   basis_out     out  9*W   committed basis to the renderer
//   commit_out    out  1     one-cycle pulse: basis_out updated this cycle
//   busy_out      out  1     high while waiting for the compute unit
//   timeout_out   out  1     sticky: a request timed out
//   missed_out    out  8     saturating count of frames missed while waiting
module camera_update_scheduler #(
    parameter int W         = 32,
    parameter int FRAC      = 16,
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 65535
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             new_frame_in,
    output logic             start_out,
    input  logic             done_in,
    input  logic [9*W-1:0]   basis_in,
    input  logic             dbg_en_in,
    input  logic [9*W-1:0]   dbg_basis_in,
    output logic [9*W-1:0]   basis_out,
    output logic             commit_out,
    output logic             busy_out,
    output logic             timeout_out,
    output logic [7:0]       missed_out
);

    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1) << FRAC;
    // forward (0,0,ONE), up (0,ONE,0), right (ONE,0,0)
    localparam logic [9*W-1:0] RESET_BASIS =
        {ZERO, ZERO, ONE, ZERO, ONE, ZERO, ONE, ZERO, ZERO};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [9*W-1:0]  shadow;

    logic            due;
    logic            tmo_hit;
    logic [9*W-1:0]  captured;

    // due is evaluated on the pre-increment divider value of the current pulse
    assign due      = (div_cnt == '0);
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    assign captured = dbg_en_in ? dbg_basis_in : basis_in;

    // NOTE: all state, including the wide shadow and output basis, is reset
    // here because a discarded READY shadow and the identity basis at power-up
    // are both part of the observable behaviour; use <= only in this block so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            tmo_cnt     <= '0;
            shadow      <= RESET_BASIS;
            basis_out   <= RESET_BASIS;
            start_out   <= 1'b0;
            commit_out  <= 1'b0;
            busy_out    <= 1'b0;
            timeout_out <= 1'b0;
            missed_out  <= 8'd0;
        end else begin
            // pulse outputs default low so they are exactly one cycle wide
            start_out  <= 1'b0;
            commit_out <= 1'b0;

            if (new_frame_in) begin
                div_cnt <= (div_cnt == DW'(FRAME_DIV - 1)) ? '0 : div_cnt + DW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (new_frame_in && due) begin
                        start_out <= 1'b1;
                        tmo_cnt   <= '0;
                        busy_out  <= 1'b1;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (done_in) begin
                        shadow <= captured;
                        if (new_frame_in) begin
                            // result arrived on the frame edge: commit without
                            // parking in READY for a whole extra frame
                            basis_out  <= captured;
                            commit_out <= 1'b1;
                            if (due) begin
                                start_out <= 1'b1;
                                tmo_cnt   <= '0;
                            end else begin
                                busy_out <= 1'b0;
                                state    <= S_IDLE;
                            end
                        end else begin
                            busy_out <= 1'b0;
                            state    <= S_READY;
                        end
                    end else begin
                        if (new_frame_in && missed_out != 8'hFF) begin
                            missed_out <= missed_out + 8'd1;
                        end
                        if (tmo_hit) begin
                            timeout_out <= 1'b1;
                            busy_out    <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end

                S_READY: begin
                    if (new_frame_in) begin
                        basis_out  <= shadow;
                        commit_out <= 1'b1;
                        if (due) begin
                            start_out <= 1'b1;
                            tmo_cnt   <= '0;
                            busy_out  <= 1'b1;
                            state     <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_update_scheduler.sv
// tb_camera_update_scheduler
//   Directed bench with two scheduler instances:
//   dut_a: FRAME_DIV=1, TIMEOUT=65535 (normal flow, debug override,
//          coincident done/new_frame, missed counting, async reset)
//   dut_b: FRAME_DIV=3, TIMEOUT=50    (frame division, timeout, idle done)
module tb_camera_update_scheduler;

    localparam int W  = 32;
    localparam int BW = 9 * W;
    localparam logic [W-1:0] ONE = 32'h0001_0000;
    localparam logic [W-1:0] Z   = 32'h0;
    localparam logic [BW-1:0] RST_BASIS = {Z, Z, ONE, Z, ONE, Z, ONE, Z, Z};

    logic clk = 1'b0;
    logic rst;
    logic [BW-1:0] basis;
    logic [BW-1:0] dbg_basis;
    logic dbg_en;

    logic nf_a, done_a;
    logic start_a, commit_a, busy_a, tmo_a;
    logic [BW-1:0] basis_a;
    logic [7:0] missed_a;

    logic nf_b, done_b;
    logic start_b, commit_b, busy_b, tmo_b;
    logic [BW-1:0] basis_b;
    logic [7:0] missed_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    camera_update_scheduler #(.W(W), .FRAC(16), .FRAME_DIV(1), .TIMEOUT(65535)) dut_a (
        .clk_in(clk), .rst_in(rst), .new_frame_in(nf_a), .start_out(start_a),
        .done_in(done_a), .basis_in(basis), .dbg_en_in(dbg_en),
        .dbg_basis_in(dbg_basis), .basis_out(basis_a), .commit_out(commit_a),
        .busy_out(busy_a), .timeout_out(tmo_a), .missed_out(missed_a)
    );

    camera_update_scheduler #(.W(W), .FRAC(16), .FRAME_DIV(3), .TIMEOUT(50)) dut_b (
        .clk_in(clk), .rst_in(rst), .new_frame_in(nf_b), .start_out(start_b),
        .done_in(done_b), .basis_in(basis), .dbg_en_in(dbg_en),
        .dbg_basis_in(dbg_basis), .basis_out(basis_b), .commit_out(commit_b),
        .busy_out(busy_b), .timeout_out(tmo_b), .missed_out(missed_b)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mk(input logic [W-1:0] base);
        logic [BW-1:0] v;
        for (int i = 0; i < 9; i++) v[i*W +: W] = base + W'(i) * 32'h111;
        return v;
    endfunction

    task automatic pulse_a();
        nf_a = 1'b1; tick(); nf_a = 1'b0;
    endtask

    task automatic pulse_b();
        nf_b = 1'b1; tick(); nf_b = 1'b0;
    endtask

    logic [BW-1:0] k1, k2, k3, k4, kb, d1;

    initial begin
        k1 = mk(32'h0000_1000);
        k2 = mk(32'h0002_2000);
        k3 = mk(32'h0003_3000);
        k4 = mk(32'h0004_4000);
        kb = mk(32'h000B_B000);
        d1 = mk(32'hFFFF_D000);

        rst = 1'b1; nf_a = 0; done_a = 0; nf_b = 0; done_b = 0;
        dbg_en = 0; basis = '0; dbg_basis = '0;
        repeat (3) tick();

        // ---- reset state
        check("rst_basis", basis_a, RST_BASIS);
        check("rst_flags", {start_a, commit_a, busy_a, tmo_a}, 4'b0000);
        check("rst_missed", missed_a, 8'd0);
        rst = 1'b0;
        tick();

        // ---- first request: start exactly one cycle after new_frame
        pulse_a();
        check("a_start_t1", start_a, 1'b1);
        check("a_busy", busy_a, 1'b1);
        tick();
        check("a_start_1wide", start_a, 1'b0);

        // ---- normal flow: result well before next frame is held back
        repeat (98) tick();
        basis = k1; done_a = 1'b1; tick(); done_a = 1'b0; basis = '0;
        check("a_no_early_commit", commit_a, 1'b0);
        check("a_basis_held", basis_a, RST_BASIS);
        check("a_ready_not_busy", busy_a, 1'b0);
        repeat (10) tick();
        check("a_basis_held2", basis_a, RST_BASIS);
        pulse_a();
        check("a_commit", commit_a, 1'b1);
        check("a_basis_k1", basis_a, k1);
        check("a_start_with_commit", start_a, 1'b1);
        tick();
        check("a_commit_1wide", {commit_a, start_a}, 2'b00);
        check("a_basis_k1_stable", basis_a, k1);

        // ---- debug override wins at capture time
        repeat (5) tick();
        basis = k2; dbg_basis = d1; dbg_en = 1'b1; done_a = 1'b1;
        tick();
        done_a = 1'b0; dbg_en = 1'b0; basis = '0; dbg_basis = '0;
        repeat (3) tick();
        pulse_a();
        check("a_dbg_commit", commit_a, 1'b1);
        check("a_basis_dbg", basis_a, d1);

        // ---- done coincident with new_frame: commit without extra frame
        repeat (5) tick();
        basis = k3; done_a = 1'b1; nf_a = 1'b1;
        tick();
        done_a = 1'b0; nf_a = 1'b0; basis = '0;
        check("a_coinc_commit", commit_a, 1'b1);
        check("a_coinc_basis", basis_a, k3);
        check("a_coinc_start", start_a, 1'b1);
        check("a_coinc_busy", busy_a, 1'b1);

        // ---- frames missed while waiting, then saturation
        for (int i = 0; i < 3; i++) begin
            tick();
            pulse_a();
        end
        check("a_missed3", missed_a, 8'd3);
        check("a_missed_no_commit", {commit_a, start_a, busy_a}, 3'b001);
        check("a_missed_basis", basis_a, k3);
        for (int i = 0; i < 260; i++) begin
            pulse_a();
            tick();
        end
        check("a_missed_sat", missed_a, 8'd255);

        // ---- async reset mid-WAIT
        rst = 1'b1;
        #1;
        check("a_async_basis", basis_a, RST_BASIS);
        check("a_async_flags", {start_a, commit_a, busy_a, tmo_a}, 4'b0000);
        check("a_async_missed", missed_a, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        basis = k4; done_a = 1'b1; tick(); done_a = 1'b0;
        check("a_late_done_ignored", {commit_a, busy_a}, 2'b00);
        pulse_a();
        check("a_restart", start_a, 1'b1);
        check("a_restart_basis", basis_a, RST_BASIS);

        // ---- async reset mid-READY discards the shadow
        repeat (4) tick();
        basis = k4; done_a = 1'b1; tick(); done_a = 1'b0; basis = '0;
        check("a_in_ready", busy_a, 1'b0);
        rst = 1'b1;
        #1;
        check("a_ready_rst_basis", basis_a, RST_BASIS);
        tick();
        rst = 1'b0;
        tick();
        pulse_a();
        check("a_shadow_discarded_commit", commit_a, 1'b0);
        check("a_shadow_discarded_basis", basis_a, RST_BASIS);
        check("a_after_ready_rst_start", start_a, 1'b1);

        // ---- dut_b: FRAME_DIV=3, TIMEOUT=50
        rst = 1'b1; tick(); rst = 1'b0; tick();
        pulse_b();                                  // frame 0
        check("b_f0_start", start_b, 1'b1);
        repeat (5) tick();
        basis = kb; done_b = 1'b1; tick(); done_b = 1'b0; basis = '0;
        tick();
        pulse_b();                                  // frame 1
        check("b_f1_commit", commit_b, 1'b1);
        check("b_f1_basis", basis_b, kb);
        check("b_f1_no_start", {start_b, busy_b}, 2'b00);
        tick();
        pulse_b();                                  // frame 2
        check("b_f2_no_start", {start_b, commit_b}, 2'b00);
        tick();
        pulse_b();                                  // frame 3
        check("b_f3_start", start_b, 1'b1);

        // timeout: 50 cycles after start_out with no done
        repeat (49) tick();
        check("b_tmo_not_yet", {tmo_b, busy_b}, 2'b01);
        tick();
        check("b_tmo_set", {tmo_b, busy_b}, 2'b10);
        check("b_tmo_basis_kept", basis_b, kb);

        // done while idle is ignored
        basis = k4; done_b = 1'b1; tick(); done_b = 1'b0; basis = '0;
        check("b_idle_done", {commit_b, busy_b}, 2'b00);
        pulse_b();                                  // frame 4
        check("b_f4", {start_b, commit_b}, 2'b00);
        check("b_f4_basis", basis_b, kb);
        tick();
        pulse_b();                                  // frame 5
        check("b_f5", start_b, 1'b0);
        tick();
        pulse_b();                                  // frame 6
        check("b_f6_start", start_b, 1'b1);
        check("b_tmo_sticky", tmo_b, 1'b1);
        check("b_missed_zero", missed_b, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
